// File: rtl/onehot_encoder_pipe.sv
// One-hot to binary index encoder behind a valid/ready handshake with a 2-entry output buffer.
// Zero and multi-hot words are flagged and tallied in a saturating error counter.
module onehot_encoder_pipe #(
    parameter int N         = 8,
    parameter int PRIO_MODE = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_code,
    output logic                  out_zero,
    output logic                  out_multi,
    input  logic                  clr_err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);
    localparam int W = $clog2(N);

    typedef struct packed {
        logic [W-1:0] code;
        logic         zero;
        logic         multi;
    } entry_t;

    entry_t               head_q, head_d, tail_q, tail_d, enc;
    logic [1:0]           count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [W-1:0]         low_idx;
    logic                 push, pop, bad;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_data[i]) low_idx = W'(i);
        end
    end

    always_comb begin
        enc       = '0;
        enc.zero  = ~|in_data;
        enc.multi = |(in_data & (in_data - N'(1)));
        if (enc.zero || (enc.multi && PRIO_MODE == 0)) enc.code = '1;
        else                                            enc.code = low_idx;
    end

    assign push = in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & out_ready;
    assign bad  = enc.zero | enc.multi;

    // head_q is the visible entry; it keeps the last popped value while empty.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = enc;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = enc;
                end else if (push) begin
                    tail_d  = enc;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
        in_ready_d = (count_d != 2'd2);
    end

    always_comb begin
        err_d = err_q;
        if (clr_err)                  err_d = (push && bad) ? ERR_CNT_W'(1) : '0;
        else if (push && bad && !(&err_q)) err_d = err_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            err_q      <= '0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_code  = head_q.code;
    assign out_zero  = head_q.zero;
    assign out_multi = head_q.multi;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed and randomized checks of onehot_encoder_pipe in two configurations:
// A = N8/strict/8-bit counter, B = N5/priority/2-bit counter.
module tb_onehot_encoder_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_iv, a_ir, a_ov, a_or, a_zero, a_multi, a_clr;
    logic [7:0] a_d, a_err;
    logic [2:0] a_code;
    logic       b_iv, b_ir, b_ov, b_or, b_zero, b_multi, b_clr;
    logic [4:0] b_d;
    logic [2:0] b_code;
    logic [1:0] b_err;

    onehot_encoder_pipe #(.N(8), .PRIO_MODE(0), .ERR_CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_or), .out_code(a_code), .out_zero(a_zero),
        .out_multi(a_multi), .clr_err(a_clr), .err_cnt(a_err));

    onehot_encoder_pipe #(.N(5), .PRIO_MODE(1), .ERR_CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_or), .out_code(b_code), .out_zero(b_zero),
        .out_multi(b_multi), .clr_err(b_clr), .err_cnt(b_err));

    int n_pass = 0, n_total = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        a_iv = 1'b1; a_d = d;
        step();
        a_iv = 1'b0;
    endtask

    task automatic push_b(input logic [4:0] d, input logic c);
        b_iv = 1'b1; b_d = d; b_clr = c;
        step();
        b_iv = 1'b0; b_clr = 1'b0;
    endtask

    // Independent reference for the strict N=8 configuration: {code, zero, multi}.
    function automatic logic [4:0] ref_a(input logic [7:0] d);
        int ones = $countones(d);
        logic [2:0] idx = 3'd0;
        for (int i = 0; i < 8; i++) if (d == (8'd1 << i)) idx = 3'(i);
        if (ones == 0) return {3'd7, 1'b1, 1'b0};
        if (ones > 1)  return {3'd7, 1'b0, 1'b1};
        return {idx, 1'b0, 1'b0};
    endfunction

    logic [4:0] sb[$];
    logic [4:0] e;
    int         exp_err;
    logic       acc, popv;

    initial begin
        rst_n = 1'b0;
        a_iv = 0; a_or = 0; a_d = 0; a_clr = 0;
        b_iv = 0; b_or = 0; b_d = 0; b_clr = 0;
        #12 rst_n = 1'b1;

        chk("rst_a_ov", a_ov, 0);  chk("rst_a_ir", a_ir, 1);
        chk("rst_a_out", {a_code, a_zero, a_multi}, 0);  chk("rst_a_err", a_err, 0);
        chk("rst_b_ov", b_ov, 0);  chk("rst_b_ir", b_ir, 1);  chk("rst_b_err", b_err, 0);

        // plain one-hot, one-cycle latency
        a_or = 1'b1;
        push_a(8'h01); chk("t1_v0", a_ov, 1); chk("t1_c0", {a_code, a_zero, a_multi}, {3'd0, 2'b00});
        push_a(8'h04); chk("t1_c2", {a_code, a_zero, a_multi}, {3'd2, 2'b00});
        push_a(8'h80); chk("t1_c7", {a_code, a_zero, a_multi}, {3'd7, 2'b00});
        step();        chk("t1_empty", a_ov, 0); chk("t1_hold", a_code, 3'd7);

        // error words, strict mode
        push_a(8'h00); chk("t2_zero", {a_code, a_zero, a_multi}, {3'd7, 2'b10});
        push_a(8'h12); chk("t2_multi", {a_code, a_zero, a_multi}, {3'd7, 2'b01});
        chk("t2_err", a_err, 2);
        step();

        // backpressure
        a_or = 1'b0;
        push_a(8'h02); chk("t3_ir1", a_ir, 1); chk("t3_c1", a_code, 3'd1);
        push_a(8'h08); chk("t3_ir0", a_ir, 0); chk("t3_head", a_code, 3'd1);
        a_iv = 1'b1; a_d = 8'h10;
        step();        chk("t3_held", a_ir, 0); chk("t3_stable", a_code, 3'd1);
        a_or = 1'b1;
        step();        chk("t3_c3", a_code, 3'd3); chk("t3_ir_back", a_ir, 1);
        step();        a_iv = 1'b0; chk("t3_c4", a_code, 3'd4); chk("t3_v", a_ov, 1);
        step();        chk("t3_drained", a_ov, 0); chk("t3_err", a_err, 2);
        a_clr = 1'b1;
        step();        a_clr = 1'b0; chk("clr_alone", a_err, 0);

        // priority mode, N=5, 2-bit saturating counter
        b_or = 1'b1;
        push_b(5'b10000, 0); chk("b_c4", {b_code, b_zero, b_multi}, {3'd4, 2'b00});
        push_b(5'b00000, 0); chk("b_zero", {b_code, b_zero, b_multi}, {3'd7, 2'b10});
        push_b(5'b10010, 0); chk("b_prio", {b_code, b_zero, b_multi}, {3'd1, 2'b01});
        chk("b_err2", b_err, 2);
        b_clr = 1'b1; step(); b_clr = 1'b0; chk("b_clr", b_err, 0);
        push_b(5'b00000, 0); chk("b_sat1", b_err, 1);
        push_b(5'b00000, 0); chk("b_sat2", b_err, 2);
        push_b(5'b00000, 0); chk("b_sat3", b_err, 3);
        push_b(5'b00000, 0); chk("b_sat4", b_err, 3);
        push_b(5'b00000, 0); chk("b_sat5", b_err, 3);
        push_b(5'b00000, 1); chk("b_clr_acc", b_err, 1);
        push_b(5'b01000, 0); chk("b_c3", b_code, 3'd3);
        step();

        // random traffic on A against the scoreboard
        exp_err = 0;
        for (int i = 0; i < 700; i++) begin
            a_iv = (i < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_or = 1'($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       a_d = 8'h00;
                1:       a_d = 8'($urandom);
                default: a_d = 8'h01 << $urandom_range(0, 7);
            endcase
            #2;
            chk("r_ov", a_ov, (sb.size() > 0));
            chk("r_ir", a_ir, (sb.size() < 2));
            acc  = a_iv && a_ir;
            popv = a_ov && a_or;
            if (popv && sb.size() > 0) begin
                chk("r_data", {a_code, a_zero, a_multi}, sb[0]);
                void'(sb.pop_front());
            end
            if (acc) begin
                e = ref_a(a_d);
                sb.push_back(e);
                if ((e[1] || e[0]) && exp_err < 255) exp_err++;
            end
            step();
        end
        chk("r_empty", sb.size(), 0);
        chk("r_err", a_err, exp_err);

        // async reset with two entries buffered
        b_or = 1'b0;
        push_b(5'b10000, 0);
        push_b(5'b00001, 0);
        chk("pre_rst_ir", b_ir, 0); chk("pre_rst_ov", b_ov, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", b_ov, 0); chk("arst_ir", b_ir, 1); chk("arst_err", b_err, 0);
        chk("arst_code", b_code, 0);
        #3 rst_n = 1'b1;
        b_or = 1'b1;
        step(); step();
        chk("post_rst_ov", b_ov, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
